// File: rtl/afifo_pkg.sv
// Shared constants for the AFIFO read-side stream: FSM encoding and output buffer depth.
// No logic; imported by afifo_rd_stream and stream_buf2.
package afifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry register FIFO with fall-through: a push into an empty buffer is visible on o_dat the same cycle.
// Latency 0 when empty. o_vld holds with o_dat stable until i_rdy; the caller must never push into a full buffer.
module stream_buf2
  import afifo_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [W-1:0] o_dat,
  output logic [1:0]   o_occ
);

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [W-1:0] r_e0;
  logic [W-1:0] r_e1;
  logic [1:0]   r_occ;
  logic         w_pop;
  logic         w_has;

  assign w_has = (r_occ != 2'd0);
  assign o_vld = w_has | i_push;
  assign o_dat = w_has ? r_e0 : (i_push ? i_dat : '0);
  assign w_pop = o_vld & i_rdy;
  assign o_occ = r_occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_occ <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_occ != FULL) begin
            if (r_occ == 2'd0) r_e0 <= i_dat;
            else               r_e1 <= i_dat;
            r_occ <= r_occ + 2'd1;
          end
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          // Empty buffer: the pushed word went straight out, nothing to store.
          if (r_occ == FULL) begin
            r_e0 <= r_e1;
            r_e1 <= i_dat;
          end else if (r_occ == 2'd1) begin
            r_e0 <= i_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/afifo_rd_stream.sv
// AFIFO read-port consumer: credit-limited fifo_rd_en, 2-entry output buffer, burst framing, drain and beat count.
// fifo_rd_en at N gives m_valid at N+1; 1 beat/clk sustained; m_ready low stops reads once the buffer holds 2.
module afifo_rd_stream
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_inflight;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic [CNT_WIDTH-1:0]  r_word_cnt;

  logic                  w_is_run;
  logic                  w_pop;
  logic                  w_last_tag;
  logic                  w_all_empty;
  logic [1:0]            w_occ;
  logic [2:0]            w_used;
  logic                  w_buf_vld;
  logic [DATA_WIDTH:0]   w_buf_dat;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (enable)      w_state_nxt = RUN;
      RUN:     if (!enable)     w_state_nxt = DRAIN;
      DRAIN:   if (w_all_empty) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_is_run = 1'b0;
    busy     = 1'b0;
    unique case (r_state)
      RUN: begin
        w_is_run = 1'b1;
        busy     = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  // ---------------- credit logic ----------------
  // A pop this cycle frees its slot in time for the word requested now.
  assign w_pop       = w_buf_vld & m_ready;
  assign w_used      = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_rd_en  = w_is_run & ~fifo_empty & (w_used < 3'(BUF_DEPTH));
  assign w_all_empty = (w_occ == 2'd0) & ~r_inflight;

  // ---------------- beat framing ----------------
  // The last flag is fixed when the word arrives; order is preserved, so the arrival
  // sequence and the handshake sequence see the same beat index for each word.
  assign w_last_tag = (r_beat_cnt == (r_len - LEN_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_len      <= LEN_WIDTH'(1);
      r_beat_cnt <= '0;
      r_word_cnt <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      if (r_state == IDLE && enable) begin
        r_len      <= (burst_len == '0) ? LEN_WIDTH'(1) : burst_len;
        r_beat_cnt <= '0;
      end else if (r_inflight) begin
        r_beat_cnt <= w_last_tag ? '0 : r_beat_cnt + LEN_WIDTH'(1);
      end
      if (w_pop) r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
    end
  end

  // ---------------- output buffer ----------------
  stream_buf2 #(
    .W (DATA_WIDTH + 1)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_inflight),
    .i_dat  ({w_last_tag, fifo_rdata}),
    .o_vld  (w_buf_vld),
    .i_rdy  (m_ready),
    .o_dat  (w_buf_dat),
    .o_occ  (w_occ)
  );

  assign m_valid  = w_buf_vld;
  assign m_data   = w_buf_dat[DATA_WIDTH-1:0];
  assign m_last   = w_buf_vld & w_buf_dat[DATA_WIDTH];
  assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Randomised bench for afifo_rd_stream: FIFO source model, scoreboard queue and negedge monitor.
module tb_afifo_rd_stream;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int CW = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [LW-1:0] burst_len;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rdata;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic [CW-1:0] word_cnt;

  always #5 clk = ~clk;

  afifo_rd_stream #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .burst_len  (burst_len),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .word_cnt   (word_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          last;
  } beat_t;

  // Source FIFO contents: written by stimulus (wp), consumed by the monitor (rp).
  logic [DW-1:0] src_mem [0:1023];
  int            wp = 0;
  int            rp = 0;

  beat_t         exp_q[$];
  int            n_chk   = 0;
  int            n_fail  = 0;
  int            mstate  = M_IDLE;
  int            k       = 0;
  int            len     = 1;
  int            exp_cnt = 0;
  logic          pend_vld = 1'b0;
  logic [DW-1:0] pend_dat = '0;
  logic          prev_hold = 1'b0;
  beat_t         prev_b = '0;
  logic          prev_rst = 1'b1;
  logic          timeout_flag = 1'b0;
  logic          rdy_rand = 1'b0;
  logic          tog = 1'b0;
  logic          force_e = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: everything here describes the clock edge that follows this negedge.
  always @(negedge clk) begin : mon
    int    sz;
    int    popn;
    logic  exp_rd;
    beat_t b;
    if (rst) begin
      if (fifo_rd_en && wp != rp) rp++;
      exp_q.delete();
      mstate    = M_IDLE;
      exp_cnt   = 0;
      pend_vld  = 1'b0;
      prev_hold = 1'b0;
      prev_rst  = 1'b1;
    end else begin
      if (prev_rst) begin
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
      end
      prev_rst = 1'b0;
      chk("timeout", timeout_flag, 0);
      sz = exp_q.size();
      chk("busy", busy, mstate != M_IDLE);
      chk("word_cnt", word_cnt, exp_cnt % 16);
      chk("m_valid", m_valid, sz > 0);
      if (prev_hold) begin
        chk("hold_data", m_data, prev_b.dat);
        chk("hold_last", m_last, prev_b.last);
      end
      popn = 0;
      if (m_valid && m_ready && sz > 0) begin
        b = exp_q.pop_front();
        chk("m_data", m_data, b.dat);
        chk("m_last", m_last, b.last);
        exp_cnt++;
        popn = 1;
      end
      prev_hold = m_valid & ~m_ready;
      prev_b    = {m_data, m_last};
      exp_rd = (mstate == M_RUN) && !fifo_empty && (sz - popn < 2);
      chk("rd_en", fifo_rd_en, exp_rd);
      pend_vld = 1'b0;
      if (fifo_rd_en) begin
        chk("rd_on_empty", fifo_empty, 0);
        if (wp != rp) begin
          pend_dat = src_mem[rp % 1024];
          rp++;
          pend_vld = 1'b1;
          exp_q.push_back({pend_dat, (k == len - 1)});
          k = (k == len - 1) ? 0 : k + 1;
        end
      end
      case (mstate)
        M_IDLE: if (enable) begin
          mstate = M_RUN;
          k      = 0;
          len    = (burst_len == 0) ? 1 : int'(burst_len);
        end
        M_RUN:   if (!enable) mstate = M_DRAIN;
        M_DRAIN: if (sz == 0) mstate = M_IDLE;
        default: mstate = M_IDLE;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    fifo_rdata = pend_vld ? pend_dat : DW'($urandom);
    force_e    = tog ? ~force_e : 1'b0;
    fifo_empty = (wp == rp) | force_e;
    if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      src_mem[wp % 1024] = DW'(base + i);
      wp++;
    end
  endtask

  task automatic wait_done(input int maxc);
    int c;
    c = 0;
    while (!(wp == rp && exp_q.size() == 0) && c < maxc) begin
      step();
      c++;
    end
    if (c >= maxc) timeout_flag = 1'b1;
  endtask

  task automatic wait_idle(input int maxc);
    int c;
    c = 0;
    while (mstate != M_IDLE && c < maxc) begin
      step();
      c++;
    end
    if (c >= maxc) timeout_flag = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0; burst_len = 8'd4;
    fifo_empty = 1'b1; fifo_rdata = '0;
    repeat (3) step();
    rst = 1'b0;

    // Back-to-back 4-beat bursts at full rate
    fill(8, 0); burst_len = 8'd4; m_ready = 1'b1; enable = 1'b1;
    wait_done(100); enable = 1'b0; wait_idle(20);

    // Backpressure: buffer fills, reads stop, then drains in order
    m_ready = 1'b0; fill(8, 32'h100); enable = 1'b1;
    repeat (12) step();
    m_ready = 1'b1;
    wait_done(100); enable = 1'b0; wait_idle(20);

    // Drop enable mid-burst with a read in flight
    burst_len = 8'd4; fill(10, 32'h200); enable = 1'b1;
    repeat (4) step();
    enable = 1'b0; wait_idle(20);

    // burst_len 0 frames every beat; a change while running waits for the next start
    burst_len = 8'd0; enable = 1'b1; fill(6, 32'h300);
    repeat (3) step();
    burst_len = 8'd3;
    wait_done(100); enable = 1'b0; wait_idle(20);
    fill(7, 32'h400); enable = 1'b1;
    wait_done(100); enable = 1'b0; wait_idle(20);

    // Reset with a full buffer discards it; stream restarts cleanly
    m_ready = 1'b0; burst_len = 8'd4; fill(6, 32'h500); enable = 1'b1;
    repeat (8) step();
    rst = 1'b1; step(); rst = 1'b0;
    m_ready = 1'b1;
    wait_done(100); enable = 1'b0; wait_idle(20);

    // Toggling empty flag and random ready; word_cnt wraps several times
    tog = 1'b1; rdy_rand = 1'b1; burst_len = 8'd5; fill(40, 32'h600); enable = 1'b1;
    wait_done(2000); enable = 1'b0; wait_idle(50);
    tog = 1'b0; rdy_rand = 1'b0; m_ready = 1'b1;

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
